// File: rtl/omsp_spm_key_loader_pkg.sv
// Shared helpers for the SPM key loader and related SPM sequencers.
package omsp_spm_key_loader_pkg;

  localparam int unsigned KEY_WORD_W = 16;

  typedef logic [KEY_WORD_W-1:0] key_word_t;

  // Number of 16-bit words making up a key of the given bit width.
  function automatic int unsigned key_words(input int unsigned security);
    return security / KEY_WORD_W;
  endfunction

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/omsp_spm_timeout.sv
// Loadable down-counter used as a cycle watchdog by SPM sequencers.
// clear reloads the counter; enable counts down towards zero and
// expired flags an enabled cycle with the counter already at zero.
module omsp_spm_timeout
  import omsp_spm_key_loader_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             mclk,
  input  logic             puc_rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] cnt;

  // Reload on clear, otherwise count down while enabled and saturate at zero.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= load_val;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = enable & (cnt == '0);

endmodule

// File: rtl/omsp_spm_key_loader.sv
// Installs a freshly derived module key into the SPM array: kicks the
// key-derivation unit, takes the key as a stream of 16-bit words and
// writes each word through the SPM key-write port. Reports done, or
// error on abort / derivation timeout.
module omsp_spm_key_loader
  import omsp_spm_key_loader_pkg::*;
#(
  parameter int unsigned SECURITY     = 64,
  parameter int unsigned KEY_IDX_SIZE = 2,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                    mclk,
  input  logic                    puc_rst,
  input  logic                    start,
  input  logic                    abort,
  output logic                    kdf_start,
  input  logic [15:0]             kdf_word,
  input  logic                    kdf_valid,
  output logic                    kdf_ready,
  output logic                    write_key,
  output logic [15:0]             key_in,
  output logic [KEY_IDX_SIZE-1:0] key_idx,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int unsigned N    = key_words(SECURITY);
  localparam int unsigned TO_W = cnt_width(TIMEOUT);

  localparam logic [KEY_IDX_SIZE-1:0] LAST_IDX = KEY_IDX_SIZE'(N - 1);
  // Counter starts at TIMEOUT-1 so expiry lands on the TIMEOUT-th WAIT cycle.
  localparam logic [TO_W-1:0]         TO_LOAD  = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);
  localparam logic                    TO_EN    = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KICK,
    S_WAIT,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [KEY_IDX_SIZE-1:0] word_cnt;
  logic                    handshake;
  logic                    to_expired;
  logic                    timer_expired;

  assign kdf_ready  = (state == S_WAIT) & ~abort;
  assign handshake  = kdf_valid & kdf_ready;
  assign to_expired = TO_EN & timer_expired;

  assign kdf_start  = (state == S_KICK);
  assign write_key  = (state == S_WRITE) & ~abort;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERR);

  // Wait-cycle watchdog: reloaded outside WAIT, counting only inside it.
  omsp_spm_timeout #(
    .WIDTH (TO_W)
  ) u_timeout (
    .mclk     (mclk),
    .puc_rst  (puc_rst),
    .clear    (state != S_WAIT),
    .enable   (state == S_WAIT),
    .load_val (TO_LOAD),
    .expired  (timer_expired)
  );

  // Next-state decode; abort dominates, then handshake, then timeout.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_KICK;
      S_KICK:  state_nxt = abort ? S_ERR : S_WAIT;
      S_WAIT: begin
        if (abort)           state_nxt = S_ERR;
        else if (kdf_valid)  state_nxt = S_WRITE;
        else if (to_expired) state_nxt = S_ERR;
      end
      S_WRITE: begin
        if (abort)                      state_nxt = S_ERR;
        else if (word_cnt == LAST_IDX)  state_nxt = S_DONE;
        else                            state_nxt = S_WAIT;
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Word counter: cleared on start, advanced after each non-final write.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      word_cnt <= '0;
    end else if ((state == S_IDLE) && start) begin
      word_cnt <= '0;
    end else if ((state == S_WRITE) && !abort && (word_cnt != LAST_IDX)) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end

  // Key-write data registers, loaded on each accepted derivation word.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      key_in  <= '0;
      key_idx <= '0;
    end else if (handshake) begin
      key_in  <= kdf_word;
      key_idx <= word_cnt;
    end
  end

endmodule

// File: tb/tb_omsp_spm_key_loader.sv
// Bench for omsp_spm_key_loader (SECURITY=64, TIMEOUT=8): directed table of
// load scenarios plus randomized loads, all checked against a timeline model.
module tb_omsp_spm_key_loader;

  localparam int NW   = 4;
  localparam int TO   = 8;
  localparam int MAXC = 96;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic        start, abort, kdf_valid;
  logic [15:0] kdf_word;
  logic        kdf_start, kdf_ready, write_key, busy, done, error;
  logic [15:0] key_in;
  logic [1:0]  key_idx;

  omsp_spm_key_loader #(
    .SECURITY     (64),
    .KEY_IDX_SIZE (2),
    .TIMEOUT      (TO)
  ) dut (
    .mclk      (mclk),
    .puc_rst   (puc_rst),
    .start     (start),
    .abort     (abort),
    .kdf_start (kdf_start),
    .kdf_word  (kdf_word),
    .kdf_valid (kdf_valid),
    .kdf_ready (kdf_ready),
    .write_key (write_key),
    .key_in    (key_in),
    .key_idx   (key_idx),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 mclk = ~mclk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // ---- load description and timeline model ----
  int          cur_d [NW];
  logic [15:0] cur_w [NW];
  int          cur_abort;

  bit          e_ready [MAXC];
  bit          e_write [MAXC];
  logic [1:0]  e_idx   [MAXC];
  logic [15:0] e_word  [MAXC];
  bit          in_wait [MAXC];
  bit          drv_valid [MAXC];
  logic [15:0] drv_word  [MAXC];
  int          m_end;
  bit          m_err;

  // Cycle 0 carries start, cycle 1 is the kick. Word k's wait window opens
  // at w, the source answers cur_d[k] cycles later (or never if >= TO), the
  // write follows one cycle after the answer and the next window opens after it.
  function automatic void build();
    int w;
    int hc;
    for (int c = 0; c < MAXC; c++) begin
      e_ready[c] = 0; e_write[c] = 0; e_idx[c] = '0; e_word[c] = '0;
      in_wait[c] = 0; drv_valid[c] = 0; drv_word[c] = '0;
    end
    w = 2; m_err = 0; m_end = 0;
    for (int k = 0; k < NW; k++) begin
      if (cur_d[k] >= TO) begin
        for (int c = w; c < w + TO; c++) in_wait[c] = 1;
        m_err = 1;
        m_end = w + TO;
        break;
      end
      hc = w + cur_d[k];
      for (int c = w; c <= hc; c++) in_wait[c] = 1;
      drv_valid[hc] = 1;
      drv_word[hc]  = cur_w[k];
      e_write[hc+1] = 1;
      e_idx[hc+1]   = 2'(k);
      e_word[hc+1]  = cur_w[k];
      w = hc + 2;
    end
    if (!m_err) m_end = w;
    for (int c = 0; c < MAXC; c++) e_ready[c] = in_wait[c];
    if (cur_abort > 0 && cur_abort < m_end) begin
      for (int c = cur_abort; c < MAXC; c++) begin
        e_ready[c] = 0;
        e_write[c] = 0;
      end
      m_end = cur_abort + 1;
      m_err = 1;
    end
  endfunction

  // Runs one load from an idle cycle; entered and left at posedge+1.
  task automatic run_load(output int obs_end, output int obs_wr, output bit obs_err);
    build();
    obs_end = -1; obs_wr = 0; obs_err = 0;
    for (int c = 0; c <= m_end + 1; c++) begin
      start = (c == 0) || (c >= 1 && c <= m_end && $urandom_range(2) == 0);
      abort = (cur_abort > 0 && c == cur_abort) || (c == 0 && $urandom_range(1) == 1);
      if (drv_valid[c]) begin
        kdf_valid = 1'b1;
        kdf_word  = drv_word[c];
      end else begin
        kdf_valid = !in_wait[c] && ($urandom_range(1) == 1);
        kdf_word  = 16'($urandom);
      end
      @(negedge mclk);
      chk($sformatf("kdf_start@c%0d", c), 32'(kdf_start), 32'(c == 1));
      chk($sformatf("busy@c%0d", c),      32'(busy),      32'(c >= 1 && c <= m_end));
      chk($sformatf("done@c%0d", c),      32'(done),      32'(c == m_end && !m_err));
      chk($sformatf("error@c%0d", c),     32'(error),     32'(c == m_end && m_err));
      chk($sformatf("kdf_ready@c%0d", c), 32'(kdf_ready), 32'(e_ready[c]));
      chk($sformatf("write_key@c%0d", c), 32'(write_key), 32'(e_write[c]));
      if (e_write[c]) begin
        chk($sformatf("key_in@c%0d", c),  32'(key_in),  32'(e_word[c]));
        chk($sformatf("key_idx@c%0d", c), 32'(key_idx), 32'(e_idx[c]));
      end
      if (write_key) obs_wr++;
      if ((done || error) && obs_end < 0) begin
        obs_end = c;
        obs_err = error;
      end
      @(posedge mclk); #1;
    end
    start = 1'b0; abort = 1'b0; kdf_valid = 1'b0;
  endtask

  // ---- directed scenario table ----
  typedef struct packed {
    logic [3:0][7:0]  d;
    logic [7:0]       abort_at;
    logic [3:0][15:0] w;
    logic [7:0]       exp_end;
    logic [3:0]       exp_writes;
    logic             exp_err;
  } vec_t;

  function automatic vec_t mk(input int d0, input int d1, input int d2, input int d3,
                              input int a, input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3,
                              input int e_end, input int e_wr, input bit e_err);
    vec_t v;
    v.d[0] = 8'(d0); v.d[1] = 8'(d1); v.d[2] = 8'(d2); v.d[3] = 8'(d3);
    v.abort_at = 8'(a);
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.exp_end = 8'(e_end); v.exp_writes = 4'(e_wr); v.exp_err = e_err;
    return v;
  endfunction

  vec_t tbl [10];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int  oe, ow;
    bit  oerr;

    tbl[0] = mk(0, 0, 0, 0, 0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 10, 4, 0); // nominal
    tbl[1] = mk(0, 0, 5, 0, 0, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 15, 4, 0); // stall before word 2
    tbl[2] = mk(0, 0, 3, 0, 7, 16'hB001, 16'hB002, 16'hB003, 16'hB004,  8, 2, 1); // abort in WAIT
    tbl[3] = mk(0, 0, 0, 0, 0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 10, 4, 0); // full reload after abort
    tbl[4] = mk(8, 0, 0, 0, 0, 16'hC001, 16'hC002, 16'hC003, 16'hC004, 10, 0, 1); // timeout, no valid
    tbl[5] = mk(7, 0, 0, 0, 0, 16'hD001, 16'hD002, 16'hD003, 16'hD004, 17, 4, 0); // valid in expiry cycle
    tbl[6] = mk(0, 2, 0, 0, 6, 16'hE001, 16'hE002, 16'hE003, 16'hE004,  7, 1, 1); // abort with valid
    tbl[7] = mk(0, 0, 0, 0, 1, 16'hF001, 16'hF002, 16'hF003, 16'hF004,  2, 0, 1); // abort in KICK
    tbl[8] = mk(0, 0, 0, 0, 5, 16'h5A5A, 16'hA5A5, 16'h0F0F, 16'hF0F0,  6, 1, 1); // abort in WRITE
    tbl[9] = mk(0, 0, 0, 8, 0, 16'hFFFF, 16'h0000, 16'h8001, 16'h7FFE, 16, 3, 1); // timeout on last word

    // Reset values.
    puc_rst = 1'b1; start = 1'b0; abort = 1'b0; kdf_valid = 1'b0; kdf_word = 16'h0;
    @(negedge mclk);
    chk("rst_kdf_start", 32'(kdf_start), 32'd0);
    chk("rst_kdf_ready", 32'(kdf_ready), 32'd0);
    chk("rst_write_key", 32'(write_key), 32'd0);
    chk("rst_key_in",    32'(key_in),    32'd0);
    chk("rst_key_idx",   32'(key_idx),   32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_error",     32'(error),     32'd0);
    puc_rst = 1'b0;
    @(posedge mclk); #1;

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < NW; k++) begin
        cur_d[k] = int'(tbl[i].d[k]);
        cur_w[k] = tbl[i].w[k];
      end
      cur_abort = int'(tbl[i].abort_at);
      run_load(oe, ow, oerr);
      chk($sformatf("tbl%0d_end_cycle", i), 32'(oe),   32'(tbl[i].exp_end));
      chk($sformatf("tbl%0d_writes", i),    32'(ow),   32'(tbl[i].exp_writes));
      chk($sformatf("tbl%0d_error", i),     32'(oerr), 32'(tbl[i].exp_err));
    end

    // Asynchronous reset during the first WRITE cycle.
    start = 1'b1; abort = 1'b0; kdf_valid = 1'b1; kdf_word = 16'hABCD;
    @(posedge mclk); #1 start = 1'b0;   // KICK
    @(posedge mclk); #1;                // WAIT
    @(posedge mclk); #1;                // WRITE
    chk("rstw_pre_write_key", 32'(write_key), 32'd1);
    #2 puc_rst = 1'b1;
    #1;
    chk("rstw_write_key", 32'(write_key), 32'd0);
    chk("rstw_busy",      32'(busy),      32'd0);
    chk("rstw_kdf_ready", 32'(kdf_ready), 32'd0);
    chk("rstw_kdf_start", 32'(kdf_start), 32'd0);
    chk("rstw_done",      32'(done),      32'd0);
    chk("rstw_error",     32'(error),     32'd0);
    chk("rstw_key_in",    32'(key_in),    32'd0);
    chk("rstw_key_idx",   32'(key_idx),   32'd0);
    @(posedge mclk);
    @(negedge mclk);
    puc_rst = 1'b0;
    @(posedge mclk); #1;
    for (int c = 0; c < 6; c++) begin
      @(negedge mclk);
      chk($sformatf("post_rst_write_key@%0d", c), 32'(write_key), 32'd0);
      chk($sformatf("post_rst_busy@%0d", c),      32'(busy),      32'd0);
      @(posedge mclk); #1;
    end
    kdf_valid = 1'b0;

    // Randomized loads.
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < NW; k++) begin
        cur_d[k] = ($urandom_range(7) == 0) ? int'(TO - 1 + $urandom_range(2)) : int'($urandom_range(4));
        cur_w[k] = 16'($urandom);
      end
      cur_abort = 0;
      build();
      if ($urandom_range(3) == 0) cur_abort = int'($urandom_range(m_end - 1, 1));
      run_load(oe, ow, oerr);
      chk($sformatf("rnd%0d_end_cycle", i), 32'(oe), 32'(m_end));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/omsp_spm_key_loader.md
# omsp_spm_key_loader

Sequencer that installs a freshly derived module key into a newly protected Sancus module. After the protect instruction has allocated and enabled an SM, it kicks the key-derivation unit and accepts the key as a stream of 16-bit words. Each word is driven onto the SPM array's key-write port (write_key / key_in / key_idx), one word per write. The block reports completion, or reports an error on abort or timeout so the execution unit can fault the protect instruction.

## Interface

- SECURITY, 64: key width in bits; multiple of 16; the key is N = SECURITY/16 words.
- KEY_IDX_SIZE, 2: width of key_idx; must satisfy 2^KEY_IDX_SIZE >= N.
- TIMEOUT, 255: maximum number of WAIT cycles without kdf_valid before error; 0 disables the timeout.

- mclk  in  1  system clock
- puc_rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle request to load the key of the just-created SM
- abort  in  1  cancel the load (violation, interrupt-on-fault)
- kdf_start  out  1  single-cycle pulse that starts the key-derivation unit
- kdf_word  in  16  key word from the derivation unit, most significant word first
- kdf_valid  in  1  kdf_word is valid
- kdf_ready  out  1  loader accepts kdf_word this cycle
- write_key  out  1  write strobe to the SPM array
- key_in  out  16  key word to be written
- key_idx  out  KEY_IDX_SIZE  word index within the key, 0 = first word
- busy  out  1  loader is not IDLE
- done  out  1  single-cycle pulse: all N words written
- error  out  1  single-cycle pulse: load aborted or timed out

## Operation

- State machine states: IDLE, KICK, WAIT, WRITE, DONE, ERR. Encoding is local to the block.
- IDLE:
  - start=1 -> KICK. The word counter is cleared.
  - abort is ignored in IDLE.
- KICK: kdf_start=1 for exactly this cycle -> WAIT.
- WAIT:
  - kdf_ready = (state==WAIT) & ~abort. kdf_ready is combinational and has no other terms.
  - On kdf_valid & kdf_ready, kdf_word is captured into the key_in register, key_idx takes the counter value, and the state moves to WRITE.
- WRITE:
  - write_key=1 for one cycle, with key_in and key_idx stable.
  - If the counter is N-1 -> DONE; otherwise the counter is incremented and the state moves to WAIT.
- DONE: done=1 for one cycle -> IDLE.
- ERR: error=1 for one cycle -> IDLE.
- abort=1 in KICK, WAIT or WRITE -> ERR on the next edge.
  - write_key is forced low during any cycle in which abort=1.
  - The word held in WAIT is dropped.
- Timeout:
  - The cycle counter is cleared on every entry to WAIT and counts while in WAIT with no handshake.
  - Reaching TIMEOUT -> ERR.
  - If kdf_valid arrives in the same cycle the counter reaches TIMEOUT, the handshake wins and the state goes to WRITE.
  - If abort arrives in that same cycle, abort wins over both.
- start while busy=1 is ignored. There is no queueing.
- busy = (state != IDLE). busy covers the DONE and ERR cycles.
- Words arriving with kdf_valid while kdf_ready=0 are not consumed. Holding kdf_valid until the handshake is the derivation unit's responsibility.
- The word counter is KEY_IDX_SIZE bits wide and never wraps past N-1.

## Timing

- Reset values: kdf_start=0, kdf_ready=0, write_key=0, key_in=16'h0, key_idx=0, busy=0, done=0, error=0. The state is IDLE and both counters are zero.
- Asynchronous reset asserted mid-load returns the block to IDLE immediately. No partial write strobe may follow reset release.
- key_in and key_idx are registered and hold their last values between writes.
- With kdf_valid held high permanently, the cycle sequence from the start edge is:
  - cycle 1: KICK
  - cycles 2..2N+1: alternating WAIT/WRITE
  - cycle 2N+2: DONE
  - For N=4 this places done in cycle 10 after start, and write_key high in cycles 3, 5, 7 and 9.
- Minimum spacing between write_key pulses is 2 cycles.

## Structure

- SECURITY and NB_SPMS stay as shared defines in openMSP430_defines.v. KEY_IDX_SIZE at the instantiating level is derived from them.
- State encoding and TIMEOUT are local parameters of this block and are not shared.
- One sub-module is natural: omsp_spm_timeout, a loadable down-counter with clear/enable/expired ports, reusable by other SPM sequencers.

## Test plan

- Nominal load, SECURITY=64, kdf_valid always high, words 16'h1111, 16'h2222, 16'h3333, 16'h4444:
  - write_key pulses in cycles 3/5/7/9 with key_idx 0/1/2/3 and matching key_in.
  - done in cycle 10; busy low in cycle 11.
- Stalled source, with kdf_valid delayed 5 cycles before word 2:
  - kdf_ready stays high throughout the stall.
  - No write_key pulse occurs during the stall.
  - key_idx=2 is written with the correct word; done follows the fourth write.
- Abort during WAIT after 2 words:
  - error pulse on the next cycle.
  - No further write_key; state returns to IDLE.
  - The next start performs a full 4-word load beginning at key_idx=0.
- Timeout with TIMEOUT=8 and kdf_valid never asserted:
  - error pulses exactly 8 WAIT cycles after KICK.
  - write_key stays 0 throughout.
  - Repeat with kdf_valid arriving in the expiry cycle: a write occurs and there is no error.
- Collisions:
  - start asserted while busy is ignored: kdf_start pulses only once.
  - abort together with kdf_valid in WAIT: kdf_ready=0, error pulse follows, no write.
- Reset asserted in a WRITE cycle:
  - All outputs go to 0 asynchronously.
  - After release, there is no write_key until a new start.
